// File: rtl/alu_pkg.sv
// Shared ALU-datapath definitions: opcode select encoding and width limit.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_A = 3'd0,
    OP_B = 3'd1,
    OP_C = 3'd2,
    OP_D = 3'd3,
    OP_E = 3'd4,
    OP_F = 3'd5,
    OP_G = 3'd6,
    OP_H = 3'd7
  } opsel_e;

  localparam int MAX_WIDTH = 128;

endpackage

// File: rtl/mux_8to1_comb.sv
// Purely combinational 8:1 word selector; every opsel code maps to one input.
module mux_8to1_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] F,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] H,
  input  logic [2:0]       opsel,
  output logic [WIDTH-1:0] sel
);

  opsel_e op;
  assign op = opsel_e'(opsel);

  always_comb begin
    sel = A;
    case (op)
      OP_A: sel = A;
      OP_B: sel = B;
      OP_C: sel = C;
      OP_D: sel = D;
      OP_E: sel = E;
      OP_F: sel = F;
      OP_G: sel = G;
      OP_H: sel = H;
    endcase
  end

endmodule

// File: rtl/mux_8to1.sv
// Registered 8:1 selector: captures the selected word on in_valid, one-cycle latency.
module mux_8to1
  import alu_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] F,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] H,
  input  logic [2:0]       opsel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] out_reg;
  logic             out_valid_reg;

  mux_8to1_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .E     (E),
    .F     (F),
    .G     (G),
    .H     (H),
    .opsel (opsel),
    .sel   (sel)
  );

  // Data holds when idle; only the valid flag drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg       <= RESET_VAL;
      out_valid_reg <= 1'b0;
    end else begin
      if (in_valid) begin
        out_reg <= sel;
      end
      out_valid_reg <= in_valid;
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;

  a_opsel_known : assert property (@(posedge clk) disable iff (!rst_n)
    in_valid |-> !$isunknown(opsel));

endmodule

// File: tb/tb_mux_8to1.sv
// Bench for mux_8to1 at WIDTH=1 and WIDTH=128 against an array-indexed reference model.
module tb_mux_8to1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [2:0]   opsel;
  logic         d1   [8];
  logic [127:0] d128 [8];
  logic         out1;
  logic [127:0] out128;
  logic         ov1;
  logic         ov128;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  logic         exp1;
  logic [127:0] exp128;
  logic         exp_v;

  mux_8to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .A(d1[0]), .B(d1[1]), .C(d1[2]), .D(d1[3]),
    .E(d1[4]), .F(d1[5]), .G(d1[6]), .H(d1[7]),
    .opsel(opsel), .in_valid(in_valid),
    .out(out1), .out_valid(ov1)
  );

  mux_8to1 #(.WIDTH(128)) dut128 (
    .clk(clk), .rst_n(rst_n),
    .A(d128[0]), .B(d128[1]), .C(d128[2]), .D(d128[3]),
    .E(d128[4]), .F(d128[5]), .G(d128[6]), .H(d128[7]),
    .opsel(opsel), .in_valid(in_valid),
    .out(out128), .out_valid(ov128)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the output is whatever input the select indexed at the last valid edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp1   = 1'b0;
      exp128 = '0;
      exp_v  = 1'b0;
    end else begin
      if (in_valid) begin
        exp1   = d1[opsel];
        exp128 = d128[opsel];
      end
      exp_v = in_valid;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_out1",   128'(out1),  128'(exp1));
      chk("model_out128", out128,      exp128);
      chk("model_ov1",    128'(ov1),   128'(exp_v));
      chk("model_ov128",  128'(ov128), 128'(exp_v));
    end
  end

  task automatic randomize_inputs();
    for (int i = 0; i < 8; i++) begin
      d1[i]   = 1'($urandom);
      d128[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    opsel = 3'($urandom);
  endtask

  initial begin
    logic [4:0] sweep_ops [5];
    logic       sweep_exp [5];
    sweep_ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd7};
    sweep_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset held with in_valid high and non-zero data.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    opsel    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      d1[i]   = 1'b1;
      d128[i] = '1;
    end
    repeat (3) @(negedge clk);
    chk("reset_out1",   128'(out1),  128'd0);
    chk("reset_out128", out128,      128'd0);
    chk("reset_ov1",    128'(ov1),   128'd0);
    cmp_en = 1;
    #1 rst_n = 1'b1;

    // Alternating 1-bit pattern, per-nibble-replicated wide data.
    for (int i = 0; i < 8; i++) begin
      d1[i]   = i[0];
      d128[i] = {32{4'(i)}};
    end

    for (int k = 0; k < 5; k++) begin
      #1 opsel = sweep_ops[k][2:0];
      @(negedge clk);
      chk($sformatf("sweep_out1_%0d", k), 128'(out1), 128'(sweep_exp[k]));
      chk($sformatf("sweep_ov1_%0d", k), 128'(ov1), 128'd1);
    end

    for (int k = 0; k < 8; k++) begin
      #1 opsel = 3'(k);
      @(negedge clk);
      chk($sformatf("wide_out128_%0d", k), out128, {32{4'(k)}});
    end

    // Hold: capture F, then idle while F and opsel change.
    #1 opsel = 3'd5;
    @(negedge clk);
    chk("hold_capture", 128'(out1), 128'd1);
    #1 in_valid = 1'b0;
    d1[5] = 1'b0;
    opsel = 3'd0;
    @(negedge clk);
    chk("hold_out1", 128'(out1), 128'd1);
    chk("hold_ov1",  128'(ov1),  128'd0);

    // Mid-stream asynchronous reset.
    #1 in_valid = 1'b1;
    opsel = 3'd7;
    @(negedge clk);
    chk("mid_pre", out128, {32{4'd7}});
    #1 opsel = 3'd6;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_out128", out128,      128'd0);
    chk("mid_async_ov128",  128'(ov128), 128'd0);
    chk("mid_async_out1",   128'(out1),  128'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    opsel = 3'd3;
    @(negedge clk);
    chk("mid_release_out128", out128,      {32{4'd3}});
    chk("mid_release_ov128",  128'(ov128), 128'd1);

    // Random traffic with mid-cycle glitches and occasional reset pulses.
    for (int it = 0; it < 400; it++) begin
      #1 rst_n = 1'b1;
      randomize_inputs();
      in_valid = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1 randomize_inputs();
      if ($urandom_range(0, 24) == 0) begin
        #1 rst_n = 1'b0;
      end
      @(negedge clk);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
